tmds_decoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 16 +
 rtl/tmds_symbol_decode.sv | 33 +++
 rtl/tmds_decoder.sv | 144 ++++++++++++++
 tb/tb_tmds_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control-period tokens (common with the
// encoder) and the word-alignment state encoding used by the receiver.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP_WAIT,
    LOCKED
  } tmds_align_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b->8b TMDS symbol decode plus control-token classification.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic       is_ctrl,
  output logic [1:0] ctrl_val
);

  logic [7:0] d;

  always_comb begin
    // Undo the DC-balance inversion, then the XOR/XNOR transition coding.
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (sym)
      CTRL_TOKEN_00: ctrl_val = 2'b00;
      CTRL_TOKEN_01: ctrl_val = 2'b01;
      CTRL_TOKEN_10: ctrl_val = 2'b10;
      CTRL_TOKEN_11: ctrl_val = 2'b11;
      default:       is_ctrl  = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// Per-channel TMDS receiver: 2-cycle symbol decode pipeline plus a
// word-alignment FSM that hunts for control-token runs and requests bit slips.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS   = 4,
  parameter int SEARCH_CYCLES = 2048,
  parameter int SLIP_SETTLE   = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic       bitslip_out
);

  localparam int RUN_W    = $clog2(LOCK_TOKENS) + 1;
  localparam int WD_W     = $clog2(SEARCH_CYCLES) + 1;
  localparam int SETTLE_W = $clog2(SLIP_SETTLE) + 1;

  logic [9:0]        sym_p1;
  logic              vld_p1;
  logic [7:0]        dec_data_p1;
  logic              is_ctrl_p1;
  logic [1:0]        ctrl_val_p1;

  tmds_align_state_t state, state_nxt;
  logic [RUN_W-1:0]    run_cnt, run_nxt;
  logic [1:0]          prev_val;
  logic [WD_W-1:0]     wd_cnt, wd_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic                qual;
  logic                slip_nxt;

  // ---- stage 1: register symbol, classify/decode combinationally ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sym_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      sym_p1 <= tmds_in;
      vld_p1 <= 1'b1;
    end
  end

  tmds_symbol_decode u_decode (
    .sym      (sym_p1),
    .data     (dec_data_p1),
    .is_ctrl  (is_ctrl_p1),
    .ctrl_val (ctrl_val_p1)
  );

  // ---- stage 2: registered decoded outputs ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_out    <= '0;
      control_out <= '0;
      ve_out      <= 1'b0;
    end else if (vld_p1) begin
      if (is_ctrl_p1) begin
        data_out    <= '0;
        control_out <= ctrl_val_p1;
        ve_out      <= 1'b0;
      end else begin
        data_out <= dec_data_p1;
        ve_out   <= 1'b1;
      end
    end
  end

  // ---- alignment: token-run counter, watchdog and FSM on stage-1 class ----
  always_comb begin
    run_nxt = '0;
    if (vld_p1 && state != SLIP_WAIT && is_ctrl_p1) begin
      // A nonzero count implies the previous cycle also carried a token.
      if (run_cnt != '0 && ctrl_val_p1 == prev_val)
        run_nxt = (run_cnt == RUN_W'(LOCK_TOKENS)) ? run_cnt : run_cnt + RUN_W'(1);
      else
        run_nxt = RUN_W'(1);
    end
    qual = (run_nxt == RUN_W'(LOCK_TOKENS));

    state_nxt  = state;
    wd_nxt     = wd_cnt + WD_W'(1);
    settle_nxt = '0;
    slip_nxt   = 1'b0;
    case (state)
      SEARCH: begin
        if (qual) begin
          state_nxt = LOCKED;
          wd_nxt    = '0;
        end else if (wd_cnt == WD_W'(SEARCH_CYCLES - 1)) begin
          state_nxt = SLIP_WAIT;
          wd_nxt    = '0;
          slip_nxt  = 1'b1;
        end
      end
      SLIP_WAIT: begin
        wd_nxt     = '0;
        settle_nxt = settle_cnt + SETTLE_W'(1);
        if (settle_cnt == SETTLE_W'(SLIP_SETTLE - 1)) begin
          state_nxt  = SEARCH;
          settle_nxt = '0;
        end
      end
      LOCKED: begin
        if (qual) begin
          wd_nxt = '0;
        end else if (wd_cnt == WD_W'(SEARCH_CYCLES - 1)) begin
          state_nxt = SEARCH;
          wd_nxt    = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        wd_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= SEARCH;
      run_cnt     <= '0;
      prev_val    <= '0;
      wd_cnt      <= '0;
      settle_cnt  <= '0;
      locked_out  <= 1'b0;
      bitslip_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      wd_cnt     <= wd_nxt;
      settle_cnt <= settle_nxt;
      if (vld_p1 && is_ctrl_p1) prev_val <= ctrl_val_p1;
      locked_out  <= (state_nxt == LOCKED);
      bitslip_out <= slip_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: behavioural TMDS encoder drives the
// decoder, expected outputs are queued at drive time and popped two cycles on.
module tb_tmds_decoder;
  import tmds_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       locked_out;
  logic       bitslip_out;

  typedef struct packed {
    logic       chk;
    logic       ve;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         disp   = 0;
  int         cyc    = 0;
  logic [1:0] exp_ctrl = 2'b00;

  always #5 clk_in = ~clk_in;

  tmds_decoder #(
    .LOCK_TOKENS   (4),
    .SEARCH_CYCLES (64),
    .SLIP_SETTLE   (4)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tmds_in     (tmds_in),
    .data_out    (data_out),
    .control_out (control_out),
    .ve_out      (ve_out),
    .locked_out  (locked_out),
    .bitslip_out (bitslip_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_TOKEN_00;
      2'b01:   return CTRL_TOKEN_01;
      2'b10:   return CTRL_TOKEN_10;
      default: return CTRL_TOKEN_11;
    endcase
  endfunction

  function automatic int tok_idx(input logic [9:0] s);
    for (int c = 0; c < 4; c++) if (s == tok(2'(c))) return c;
    return -1;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] v, input int n);
    logic [19:0] t;
    t = {v, v} << n;
    return t[19:10];
  endfunction

  // Reference DVI encoder with running disparity held in disp.
  function automatic logic [9:0] enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] o;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      o = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      disp += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      disp += (qm[8] ? 0 : -2) + n1q - n0q;
    end
    return o;
  endfunction

  task automatic tick(input logic [9:0] sym, input logic chk, input logic [7:0] exp_data);
    exp_t e;
    int   t;
    t       = tok_idx(sym);
    tmds_in = sym;
    if (t >= 0) begin
      disp     = 0;
      exp_ctrl = 2'(t);
      e = '{chk: chk, ve: 1'b0, data: 8'h00, ctrl: exp_ctrl};
    end else begin
      e = '{chk: chk, ve: 1'b1, data: exp_data, ctrl: exp_ctrl};
    end
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    cyc++;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      if (e.chk)
        check("decode_out", 32'({ve_out, data_out, control_out}), 32'({e.ve, e.data, e.ctrl}));
    end
  endtask

  task automatic send_tok(input logic [1:0] c, input int n);
    repeat (n) tick(tok(c), 1'b1, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(enc(b), 1'b1, b);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    sb.delete();
    exp_ctrl = 2'b00;
    disp     = 0;
    check("reset_outputs",
          32'({ve_out, data_out, control_out, locked_out, bitslip_out}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int found, pulses, last, off;
    rst_in  = 1'b1;
    tmds_in = 10'h000;
    do_reset();

    // Direct decode vectors.
    tick(10'h100, 1'b1, 8'h00);
    tick(10'h200, 1'b1, 8'hFF);

    // Token run edge: 3x00 must not lock, lock on the 4th 01.
    send_tok(2'b00, 3);
    send_tok(2'b01, 3);
    check("run_short_nolock", 32'(locked_out), 32'd0);
    tick(tok(2'b01), 1'b1, 8'h00);
    check("run_4th_sampled", 32'(locked_out), 32'd0);
    send_byte(8'h5A);
    check("run_lock", 32'(locked_out), 32'd1);

    // Loopback: controls cycling, then all bytes with periodic token runs.
    for (int c = 0; c < 4; c++) send_tok(2'(c), 1);
    for (int b = 0; b < 256; b++) begin
      if (b % 16 == 0) send_tok(2'(b / 16), 4);
      send_byte(8'(b));
    end
    check("loopback_locked", 32'(locked_out), 32'd1);

    // Loss of lock after a watchdog period of data only, without slipping.
    send_tok(2'b00, 4);
    for (int k = 1; k <= 65; k++) begin
      send_byte(8'(k * 7));
      check("lol_no_slip", 32'(bitslip_out), 32'd0);
      if (k == 64) check("lol_still_locked", 32'(locked_out), 32'd1);
      if (k == 65) check("lol_dropped", 32'(locked_out), 32'd0);
    end

    // Reset while locked; re-lock needs a fresh 4-token run.
    send_tok(2'b10, 4);
    send_byte(8'h11);
    check("pre_reset_locked", 32'(locked_out), 32'd1);
    do_reset();
    tick(tok(2'b10), 1'b1, 8'h00);
    check("reset_discard", 32'({ve_out, data_out, control_out}), 32'd0);
    send_tok(2'b10, 2);
    tick(tok(2'b10), 1'b1, 8'h00);
    check("relock_not_early", 32'(locked_out), 32'd0);
    send_byte(8'h22);
    check("relock", 32'(locked_out), 32'd1);

    // Tokens arriving during SLIP_WAIT must not count toward a run.
    do_reset();
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      send_byte(8'(k));
      if (bitslip_out) found = 1;
    end
    check("slip_seen", 32'(found), 32'd1);
    tick(tok(2'b01), 1'b1, 8'h00);
    check("slip_single_cycle", 32'(bitslip_out), 32'd0);
    repeat (3) tick(tok(2'b01), 1'b1, 8'h00);
    repeat (3) send_byte(8'h3C);
    check("slipwait_ignored", 32'(locked_out), 32'd0);

    // Misalignment: token stream rotated by 3, deserializer model follows slips.
    do_reset();
    off    = 3;
    pulses = 0;
    last   = 0;
    for (int k = 0; k < 400 && !locked_out; k++) begin
      tick(rotl(CTRL_TOKEN_00, off), 1'b0, 8'h00);
      if (bitslip_out) begin
        pulses++;
        if (pulses > 1) check("slip_gap", 32'(cyc - last), 32'd68);
        last = cyc;
        if (off > 0) off--;
      end
    end
    check("slip_count", 32'(pulses), 32'd3);
    check("misalign_locked", 32'(locked_out), 32'd1);
    send_tok(2'b00, 2);
    send_byte(8'hA5);
    send_byte(8'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
